// File: rtl/opr_execute_stage.sv
// Sequences PDP-8 OPR (opcode 7) instructions: Group 1 via external decoder, Group 2/3 locally.
// Latency: accept edge -> EXEC -> WB; wb_valid is high for one cycle, two edges after accept.
// Backpressure: opr_ready is high only in IDLE; fetch holds instr until accepted; HALT waits for cont.
//
// Optional feature macro: OPR_MQ_EN (12-bit MQ register with MQA/MQL in Group 3).
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   opr_valid/opr_ready               fetch handshake; instr, pc_in, ac_in, l_in, sr sampled on accept
//   dec_i_reg/dec_ac/dec_l            latched operands driven to micro_instruction_decoder
//   dec_ac_micro/dec_l_micro/dec_g*   decoder Group 1 result and one-hot group flags
//   wb_valid, ac_out, l_out, pc_next  one-cycle write-back to the register file
//   illegal_op                        qualified by wb_valid
//   halted, cont                      HALT state indicator and release pulse
module opr_execute_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        opr_valid,
  output logic        opr_ready,
  input  logic [11:0] instr,
  input  logic [11:0] pc_in,
  input  logic [11:0] ac_in,
  input  logic        l_in,
  input  logic [11:0] sr,
  input  logic        cont,
  output logic [8:0]  dec_i_reg,
  output logic [11:0] dec_ac,
  output logic        dec_l,
  input  logic [11:0] dec_ac_micro,
  input  logic        dec_l_micro,
  input  logic        dec_g1,
  input  logic        dec_g2,
  input  logic        dec_g3,
  output logic        wb_valid,
  output logic [11:0] ac_out,
  output logic        l_out,
  output logic [11:0] pc_next,
  output logic        halted,
  output logic        illegal_op
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_HALT} state_t;

  state_t      state_q, state_d;

  // Operands captured on accept
  logic [11:0] instr_q, pc_q, ac_q, sr_q;
  logic        l_q;

  // Result captured at the end of EXEC
  logic [11:0] res_ac_q, res_pc_q;
  logic        res_l_q, res_ill_q, res_hlt_q;

  logic [11:0] ac_d, pc_d, ac_cla;
  logic        l_d, ill_d, hlt_d, skip_d, cond;
  logic        legal_op, flags_ok;

`ifdef OPR_MQ_EN
  logic [11:0] mq_q, res_mq_q, mq_d;
`endif

  assign dec_i_reg  = instr_q[8:0];
  assign dec_ac     = ac_q;
  assign dec_l      = l_q;

  assign ac_out     = res_ac_q;
  assign l_out      = res_l_q;
  assign pc_next    = res_pc_q;
  assign illegal_op = res_ill_q;

  assign legal_op = (instr_q[11:9] == 3'o7);
  assign flags_ok = (dec_g1 & ~dec_g2 & ~dec_g3) |
                    (~dec_g1 & dec_g2 & ~dec_g3) |
                    (~dec_g1 & ~dec_g2 & dec_g3);

  // Result computation; only meaningful while in EXEC
  always_comb begin
    ac_d   = ac_q;
    l_d    = l_q;
    ill_d  = 1'b0;
    hlt_d  = 1'b0;
    skip_d = 1'b0;
    cond   = 1'b0;
    ac_cla = instr_q[7] ? 12'o0000 : ac_q;
`ifdef OPR_MQ_EN
    mq_d   = mq_q;
`endif
    if (!legal_op || !flags_ok) begin
      // Broken decoder flags are handled like an illegal opcode: state passes through
      ill_d = 1'b1;
    end else if (dec_g1) begin
      ac_d = dec_ac_micro;
      l_d  = dec_l_micro;
    end else if (dec_g2) begin
      // Skip conditions look at the AC/L as latched, before any CLA
      cond   = (instr_q[6] & ac_q[11]) | (instr_q[5] & (ac_q == 12'o0000)) | (instr_q[4] & l_q);
      skip_d = cond ^ instr_q[3];
      ac_d   = ac_cla | (instr_q[2] ? sr_q : 12'o0000);
      hlt_d  = instr_q[1];
    end else begin
      ac_d = ac_cla;
`ifdef OPR_MQ_EN
      case ({instr_q[6], instr_q[4]})
        2'b11:   begin ac_d = mq_q;          mq_d = ac_cla; end
        2'b01:   begin ac_d = 12'o0000;      mq_d = ac_cla; end
        2'b10:   begin ac_d = ac_cla | mq_q;                end
        default: begin                                      end
      endcase
`endif
    end
    pc_d = pc_q + (skip_d ? 12'd2 : 12'd1);
  end

  // Next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    opr_ready = 1'b0;
    wb_valid  = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_IDLE: begin
        opr_ready = 1'b1;
        if (opr_valid) state_d = S_EXEC;
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        wb_valid = 1'b1;
        state_d  = res_hlt_q ? S_HALT : S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
        if (cont) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      pc_q      <= '0;
      ac_q      <= '0;
      l_q       <= 1'b0;
      sr_q      <= '0;
      res_ac_q  <= '0;
      res_pc_q  <= '0;
      res_l_q   <= 1'b0;
      res_ill_q <= 1'b0;
      res_hlt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && opr_valid) begin
        instr_q <= instr;
        pc_q    <= pc_in;
        ac_q    <= ac_in;
        l_q     <= l_in;
        sr_q    <= sr;
      end
      if (state_q == S_EXEC) begin
        res_ac_q  <= ac_d;
        res_l_q   <= l_d;
        res_pc_q  <= pc_d;
        res_ill_q <= ill_d;
        res_hlt_q <= hlt_d;
      end
    end
  end

`ifdef OPR_MQ_EN
  // MQ is architecturally updated together with the write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq_q     <= '0;
      res_mq_q <= '0;
    end else begin
      if (state_q == S_EXEC) res_mq_q <= mq_d;
      if (state_q == S_WB)   mq_q     <= res_mq_q;
    end
  end
`endif

  // Decoder must flag exactly one group for a legal opcode
  assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_EXEC && legal_op) |-> flags_ok);

endmodule
